button_reader: RTL and testbench
================================

# button_reader

Debounced reader for the board's eight active-low push-buttons/DIP switches, the input-side counterpart of the LED drivers. Synchronises raw pin levels, debounces each channel against a shared slow sample tick, and reports debounced state, one-cycle press/release pulses, and a change-event queue drained over a valid/ready handshake. Sits between the board pins and any consumer (LED pattern logic, mode selection).

## Interface

- `tick_div`, default 50000: clock cycles per sample tick; must be ≥2.
- `stable_n`, default 8: consecutive differing samples required to accept a new level; must be ≥1.
- `fifo_depth`, default 4: event queue entries; power of two, ≥2.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `btn_n`  in  8  raw pin levels, active-low (0 = pressed), asynchronous to `clk`.
- `state`  out  8  debounced level, active-high (1 = pressed).
- `press`  out  8  one-cycle pulse per channel on accepted 0→1 of `state`.
- `release`  out  8  one-cycle pulse per channel on accepted 1→0 of `state`.
- `evt_valid`  out  1  queue non-empty.
- `evt_ready`  in  1  consumer accepts head entry.
- `evt_data`  out  16  head entry: [15:8] new `state` snapshot, [7:0] changed-channel mask.
- `evt_overflow`  out  1  sticky: an event was dropped on a full queue.

## Operation

- Reset (`rst_n`=0 at a rising edge): synchroniser flops ← 8'hFF (released); prescaler ← 0; per-channel counters ← 0; `state`, `press`, `release` ← 0; queue emptied; `evt_valid`=0, `evt_overflow`=0. `evt_data` is don't-care while `evt_valid`=0.
- Synchroniser: two flop stages on `btn_n`; `sample` = ~stage2.
- Prescaler: counts 0..`tick_div`-1, wraps to 0; `tick` is high for the one cycle the count equals `tick_div`-1.
- Per channel i, only on `tick` cycles:
  - `sample[i]` == `state[i]`: counter ← 0.
  - differs and counter+1 < `stable_n`: counter ← counter+1.
  - differs and counter+1 == `stable_n`: `state[i]` ← `sample[i]`, counter ← 0, set `press[i]` or `release[i]`.
- Counter width: ceil(log2(`stable_n`+1)); never exceeds `stable_n`-1 after an edge.
- `press`/`release` are registered and high only for the cycle in which `state` first shows the new value; otherwise 0. Never both high on one channel.
- Event push: at the same edge `state` changes (any channel), push {new `state`, `press`|`release`}. Multiple channels changing on one tick produce one entry.
- Pop: transfer when `evt_valid` && `evt_ready` at a rising edge; head advances. `evt_ready` while `evt_valid`=0 has no effect.
- Full queue: push with simultaneous pop is accepted (count unchanged); push without pop is dropped, queue contents unchanged, `evt_overflow` ← 1. `evt_overflow` clears only on reset.
- Entries leave in push order; `evt_data` is stable while `evt_valid`=1 and not popped.

## Timing

- Pin change before edge k: `sample` reflects it after edge k+1; `state` changes at the `stable_n`-th subsequent `tick` edge, assuming the pin stays stable.
- Any return of `sample` to `state` on a tick restarts the count; bounces shorter than `stable_n` ticks produce no output.
- `evt_valid` rises in the same cycle as the corresponding `press`/`release` when the queue was empty (0-cycle push-to-valid).
- Pop-to-next-head: next entry visible the cycle after the pop edge.
- Reset mid-debounce discards partial counts; a button held through reset is re-detected, producing a `press` `stable_n` ticks after release of reset (plus 2 sync cycles).

## Test plan

Bench parameters: `tick_div`=4, `stable_n`=3, `fifo_depth`=4.
- Reset with `btn_n`=8'h00 held: during reset `state`=0, `press`=0, `release`=0, `evt_valid`=0, `evt_overflow`=0; after reset, `press`=8'hFF once after 3 ticks, single entry 16'hFFFF.
- `btn_n[0]` driven low and held: `state[0]`=1 on the 3rd tick after sync, `press[0]` high exactly 1 cycle, `evt_data`=16'h0101 with `evt_valid` same cycle; pop with `evt_ready`=1 → `evt_valid`=0 next cycle.
- `btn_n[3]` low for 2 ticks then high, repeated 5 times: `state[3]` stays 0, no pulses, no events.
- `btn_n[1]`,`btn_n[2]` low same cycle → one entry 16'h0606; later both high → `release`=8'h06, entry 16'h0006.
- `evt_ready`=0, 5 distinct press/release events → 4 entries retained in order, `evt_overflow`=1, 5th lost; with full queue and `evt_ready`=1 on the push cycle, the new entry is accepted and `evt_overflow` does not set from that push.
- `rst_n` pulsed low with 2 entries queued and a channel mid-count → queue empty, counters 0, `evt_overflow`=0; partial debounce produces no event.

Source files
------------

// File: rtl/button_reader.sv
// button_reader: two-flop synchroniser, per-channel debounce on a shared slow tick,
// press/release pulses and a small change-event queue. `release` is a reserved word, so that port is `released`.
module button_reader #(
    parameter int tick_div   = 50000,
    parameter int stable_n   = 8,
    parameter int fifo_depth = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  btn_n,
    output logic [7:0]  state,
    output logic [7:0]  press,
    output logic [7:0]  released,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [15:0] evt_data,
    output logic        evt_overflow
);
    localparam int pw = $clog2(tick_div);
    localparam int cw = $clog2(stable_n + 1);
    localparam int aw = $clog2(fifo_depth);
    localparam logic [aw:0] full_lvl = fifo_depth[aw:0];

    logic [7:0]          sync1, sync2;
    logic [7:0]          sample;
    logic [pw-1:0]       pre_q;
    logic                tick;
    logic [7:0][cw-1:0]  cnt_q, cnt_d;
    logic [7:0]          state_d, press_d, rel_d;

    logic [15:0]         mem [fifo_depth];
    logic [aw-1:0]       wr_ptr, rd_ptr;
    logic [aw:0]         count;
    logic                push, pop, full, accept;

    assign sample = ~sync2;
    assign tick   = (pre_q == pw'(tick_div - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 8'hFF;
            sync2 <= 8'hFF;
            pre_q <= '0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            pre_q <= tick ? '0 : pre_q + pw'(1);
        end
    end

    // A channel only moves after stable_n consecutive ticks that disagree with its current level.
    always_comb begin
        state_d = state;
        press_d = '0;
        rel_d   = '0;
        cnt_d   = cnt_q;
        for (int i = 0; i < 8; i++) begin
            if (tick) begin
                if (sample[i] == state[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] + cw'(1) == cw'(stable_n)) begin
                    cnt_d[i]   = '0;
                    state_d[i] = sample[i];
                    press_d[i] = sample[i];
                    rel_d[i]   = ~sample[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + cw'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            state    <= '0;
            press    <= '0;
            released <= '0;
        end else begin
            cnt_q    <= cnt_d;
            state    <= state_d;
            press    <= press_d;
            released <= rel_d;
        end
    end

    assign push      = |(press_d | rel_d);
    assign evt_valid = (count != '0);
    assign pop       = evt_valid && evt_ready;
    assign full      = (count == full_lvl);
    // When full, a same-edge pop frees the head slot, which is exactly where wr_ptr points.
    assign accept    = push && (!full || pop);
    assign evt_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {state_d, press_d | rel_d};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + aw'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + aw'(1);
            end
            if (accept && !pop) begin
                count <= count + (aw+1)'(1);
            end else if (!accept && pop) begin
                count <= count - (aw+1)'(1);
            end
            if (push && !accept) begin
                evt_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: a cycle-level reference model checked every cycle,
// plus directed scenarios with hand-derived latencies and event words.
module tb_button_reader;
    localparam int TD    = 4;
    localparam int SN    = 3;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  btn_n;
    logic [7:0]  state, press, released;
    logic        evt_valid, evt_ready, evt_overflow;
    logic [15:0] evt_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulse_cnt = 0;
    bit check_en = 0;

    button_reader #(.tick_div(TD), .stable_n(SN), .fifo_depth(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .state(state), .press(press),
        .released(released), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_data(evt_data), .evt_overflow(evt_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index since reset release: edge j is a tick edge when j % TD == TD-1.
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;
    always @(negedge clk) if ((press | released) != 8'h00) pulse_cnt <= pulse_cnt + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pins are seen two edges late; each channel counts consecutive
    // disagreeing tick samples; events go into an unbounded queue capped at DEPTH.
    logic [7:0]  m_s1, m_s2, m_state, m_press, m_rel;
    int          m_run [8];
    bit          m_ovf;
    logic [15:0] mq [$];

    always @(posedge clk) begin
        logic [7:0] smp, ns, np, nr;
        bit tk, pop;
        if (!rst_n) begin
            m_s1 = 8'hFF; m_s2 = 8'hFF;
            for (int i = 0; i < 8; i++) m_run[i] = 0;
            m_state = 0; m_press = 0; m_rel = 0; m_ovf = 0;
            mq.delete();
        end else begin
            smp = ~m_s2;
            tk  = (cyc % TD) == TD - 1;
            pop = (mq.size() != 0) && evt_ready;
            ns = m_state; np = 0; nr = 0;
            if (tk) begin
                for (int i = 0; i < 8; i++) begin
                    if (smp[i] == m_state[i]) m_run[i] = 0;
                    else begin
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] == SN) begin
                            m_run[i] = 0;
                            ns[i] = smp[i];
                            if (smp[i]) np[i] = 1'b1; else nr[i] = 1'b1;
                        end
                    end
                end
            end
            if (pop) void'(mq.pop_front());
            if ((np | nr) != 0) begin
                if (mq.size() < DEPTH) mq.push_back({ns, np | nr});
                else m_ovf = 1;
            end
            m_state = ns; m_press = np; m_rel = nr;
            m_s2 = m_s1; m_s1 = btn_n;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("m_state", {8'h00, state}, {8'h00, m_state});
            chk("m_press", {8'h00, press}, {8'h00, m_press});
            chk("m_release", {8'h00, released}, {8'h00, m_rel});
            chk("m_valid", {15'h0, evt_valid}, {15'h0, mq.size() != 0});
            chk("m_overflow", {15'h0, evt_overflow}, {15'h0, m_ovf});
            if (mq.size() != 0) chk("m_data", evt_data, mq[0]);
        end
    end

    // Drive new pins now (at a negedge) and check the accepted edge lands exactly on
    // the SN-th tick edge at or after index cyc+2; optionally pop on that same edge.
    task automatic ev(input logic [7:0] pins, input logic [7:0] ep, input logic [7:0] er,
                      input bit pop_on_push, input logic [15:0] head, input string tag);
        int t0, tp, guard;
        btn_n = pins;
        t0 = cyc + 2;
        while (t0 % TD != TD - 1) t0++;
        tp = t0 + (SN - 1) * TD;
        guard = 0;
        while (cyc < tp && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_pre_press"}, {8'h00, press}, 16'h0000);
        if (pop_on_push) evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        chk({tag, "_press"}, {8'h00, press}, {8'h00, ep});
        chk({tag, "_release"}, {8'h00, released}, {8'h00, er});
        chk({tag, "_valid"}, {15'h0, evt_valid}, 16'h0001);
        chk({tag, "_head"}, evt_data, head);
        @(negedge clk);
        chk({tag, "_pulse_end"}, {8'h00, press | released}, 16'h0000);
    endtask

    task automatic pop_one(input logic [15:0] exp, input string tag);
        chk({tag, "_valid"}, {15'h0, evt_valid}, 16'h0001);
        chk({tag, "_data"}, evt_data, exp);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p0, t0, guard;
        rst_n = 1'b0; btn_n = 8'h00; evt_ready = 1'b0;
        @(negedge clk);
        check_en = 1;
        repeat (3) @(negedge clk);
        chk("rst_state", {8'h00, state}, 16'h0000);
        chk("rst_press", {8'h00, press | released}, 16'h0000);
        chk("rst_valid", {15'h0, evt_valid}, 16'h0000);
        chk("rst_ovf", {15'h0, evt_overflow}, 16'h0000);

        // Held through reset: press of all channels 12 cycles after release.
        rst_n = 1'b1;
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            n = k;
            if (press != 8'h00) break;
        end
        chk("held_latency", 16'(n), 16'd12);
        chk("held_press", {8'h00, press}, 16'h00FF);
        chk("held_entry", evt_data, 16'hFFFF);
        chk("held_valid", {15'h0, evt_valid}, 16'h0001);
        @(negedge clk);
        chk("held_press_1cyc", {8'h00, press}, 16'h0000);
        pop_one(16'hFFFF, "pop_held");
        chk("after_pop_valid", {15'h0, evt_valid}, 16'h0000);

        ev(8'hFF, 8'h00, 8'hFF, 0, 16'h00FF, "rel_all");
        pop_one(16'h00FF, "pop_rel_all");
        ev(8'hFE, 8'h01, 8'h00, 0, 16'h0101, "press0");
        pop_one(16'h0101, "pop_press0");
        chk("press0_popped", {15'h0, evt_valid}, 16'h0000);
        ev(8'hFF, 8'h00, 8'h01, 0, 16'h0001, "rel0");
        pop_one(16'h0001, "pop_rel0");

        // Bounces of exactly two ticks never reach the third.
        p0 = pulse_cnt;
        for (int r = 0; r < 5; r++) begin
            btn_n = 8'hF7;
            repeat (2 * TD) @(negedge clk);
            btn_n = 8'hFF;
            repeat (2 * TD) @(negedge clk);
        end
        repeat (16) @(negedge clk);
        chk("bounce_pulses", 16'(pulse_cnt - p0), 16'h0000);
        chk("bounce_state", {8'h00, state}, 16'h0000);
        chk("bounce_valid", {15'h0, evt_valid}, 16'h0000);

        ev(8'hF9, 8'h06, 8'h00, 0, 16'h0606, "press12");
        pop_one(16'h0606, "pop_press12");
        ev(8'hFF, 8'h00, 8'h06, 0, 16'h0006, "rel12");
        pop_one(16'h0006, "pop_rel12");

        // Fill the queue, push-with-pop on a full queue, then a dropped push.
        ev(8'hEF, 8'h10, 8'h00, 0, 16'h1010, "q1");
        ev(8'hFF, 8'h00, 8'h10, 0, 16'h1010, "q2");
        ev(8'hDF, 8'h20, 8'h00, 0, 16'h1010, "q3");
        ev(8'hFF, 8'h00, 8'h20, 0, 16'h1010, "q4");
        chk("full_no_ovf", {15'h0, evt_overflow}, 16'h0000);
        ev(8'hBF, 8'h40, 8'h00, 1, 16'h0010, "q5_with_pop");
        chk("pushpop_no_ovf", {15'h0, evt_overflow}, 16'h0000);
        ev(8'hFF, 8'h00, 8'h40, 0, 16'h0010, "q6_dropped");
        chk("drop_ovf", {15'h0, evt_overflow}, 16'h0001);
        pop_one(16'h0010, "drain1");
        pop_one(16'h2020, "drain2");
        pop_one(16'h0020, "drain3");
        pop_one(16'h4040, "drain4");
        chk("drained_valid", {15'h0, evt_valid}, 16'h0000);
        chk("ovf_sticky", {15'h0, evt_overflow}, 16'h0001);

        // Reset with two entries queued and channel 2 two ticks into its count.
        ev(8'h7F, 8'h80, 8'h00, 0, 16'h8080, "r1");
        ev(8'hFF, 8'h00, 8'h80, 0, 16'h8080, "r2");
        btn_n = 8'hFB;
        t0 = cyc + 2;
        while (t0 % TD != TD - 1) t0++;
        guard = 0;
        while (cyc < t0 + TD + 1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst2_valid", {15'h0, evt_valid}, 16'h0000);
        chk("rst2_ovf", {15'h0, evt_overflow}, 16'h0000);
        rst_n = 1'b1;
        p0 = pulse_cnt;
        guard = 0;
        while (cyc < 9 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        btn_n = 8'hFF;
        repeat (20) @(negedge clk);
        chk("partial_pulses", 16'(pulse_cnt - p0), 16'h0000);
        chk("partial_state", {8'h00, state}, 16'h0000);
        chk("partial_valid", {15'h0, evt_valid}, 16'h0000);
        chk("partial_ovf", {15'h0, evt_overflow}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
